// File: rtl/clk_sel_pkg.sv
// clk_sel_pkg: shared state encoding and select constants for the
// glitch-free clock mux sequencer.
package clk_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic SEL_CLK1 = 1'b1;
    localparam logic SEL_CLK2 = 1'b0;

endpackage

// File: rtl/clk_sel_ctrl_tgl_sync.sv
// tgl_sync: brings a divide-by-2 toggle from a foreign clock domain into
// the reference domain and flags each change as a one-cycle event.
module tgl_sync (
    input  logic clk,
    input  logic rst,
    input  logic tgl,
    output logic evt
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tgl;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt = s2 ^ s3;

endmodule

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: arbitrates clock switch requests, proves the target clock
// is alive, moves the mux select and acknowledges after a settle window.
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int   NREQ       = 2,
    parameter int   WIN_CYC    = 32,
    parameter int   ACT_MIN    = 4,
    parameter int   SETTLE_CYC = 16,
    parameter logic RST_SEL    = SEL_CLK1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_sel,
    output logic [NREQ-1:0] req_ack,
    output logic            req_err,
    input  logic            clk1_tgl,
    input  logic            clk2_tgl,
    output logic            sel,
    output logic            busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(WIN_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int AW = $clog2(ACT_MIN + 1);

    state_e          state;
    state_e          state_nxt;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant;
    logic            tgt_q;
    logic            err_q;
    logic [WW-1:0]   win_cnt;
    logic [SW-1:0]   set_cnt;
    logic [AW-1:0]   act_cnt;
    logic [AW-1:0]   act_nxt;

    logic            req_any;
    logic [GW-1:0]   gnt_idx;
    logic [GW-1:0]   idx;
    logic            tgt_in;
    logic            evt1;
    logic            evt2;
    logic            evt_t;
    logic            win_last;
    logic            set_last;
    logic            alive;

    tgl_sync u_sync1 (
        .clk (clk),
        .rst (rst),
        .tgl (clk1_tgl),
        .evt (evt1)
    );

    tgl_sync u_sync2 (
        .clk (clk),
        .rst (rst),
        .tgl (clk2_tgl),
        .evt (evt2)
    );

    // Round-robin search begins just after the last served requester.
    always_comb begin
        req_any = 1'b0;
        gnt_idx = last_grant;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(last_grant) + i) % NREQ);
            if (!req_any && req_valid[idx]) begin
                req_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign tgt_in = req_sel[gnt_idx];

    always_comb begin
        evt_t = 1'b0;
        unique case (tgt_q)
            SEL_CLK1: evt_t = evt1;
            SEL_CLK2: evt_t = evt2;
            default:  evt_t = 1'b0;
        endcase
    end

    assign act_nxt  = (evt_t && act_cnt != AW'(ACT_MIN))
                    ? act_cnt + 1'b1 : act_cnt;
    assign alive    = (act_nxt == AW'(ACT_MIN));
    assign win_last = (win_cnt == WW'(WIN_CYC - 1));
    assign set_last = (set_cnt == SW'(SETTLE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = (tgt_in == sel) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (win_last) begin
                    state_nxt = alive ? SETTLE : DONE;
                end
            end
            SETTLE: begin
                if (set_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        req_ack = '0;
        req_err = 1'b0;
        if (state == DONE) begin
            req_ack[grant_q] = 1'b1;
            req_err          = err_q;
        end
    end

    // sel is only ever moved after the target has proven it toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            last_grant <= GW'(NREQ - 1);
            tgt_q      <= RST_SEL;
            err_q      <= 1'b0;
            win_cnt    <= '0;
            act_cnt    <= '0;
            set_cnt    <= '0;
            sel        <= RST_SEL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_q <= gnt_idx;
                        tgt_q   <= tgt_in;
                        err_q   <= 1'b0;
                        win_cnt <= '0;
                        act_cnt <= '0;
                    end
                end
                CHECK: begin
                    win_cnt <= win_cnt + 1'b1;
                    act_cnt <= act_nxt;
                    if (win_last) begin
                        if (alive) begin
                            sel     <= tgt_q;
                            set_cnt <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    set_cnt <= set_cnt + 1'b1;
                end
                DONE: begin
                    last_grant <= grant_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
